// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner: time-multiplexed driver for an 8-digit common-anode
// seven-segment display with per-frame snapshot of segment data and
// brightness, 16-step PWM per digit slot and a start-of-frame strobe.
module sevenseg_scanner #(
    parameter int unsigned SUB_SLOT_CYCLES = 6250
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [63:0] sevenseg_data,
    input  logic [31:0] display_control,
    output logic [7:0]  anode_n,
    output logic [7:0]  cathode_n,
    output logic        frame_tick
);

    localparam int unsigned PW = (SUB_SLOT_CYCLES > 1) ? $clog2(SUB_SLOT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(SUB_SLOT_CYCLES - 1);

    logic [PW-1:0] prescale;
    logic [3:0]    sub;
    logic [2:0]    digit;
    logic [63:0]   data_snap;
    logic [3:0]    bright_snap;

    logic          prescale_wrap;
    logic          sub_wrap;
    logic          frame_end;
    logic          lit;
    logic [7:0]    anode_next;
    logic [7:0]    cathode_next;

    // Control bits this block does not interpret.
    logic          unused_ctrl;
    assign unused_ctrl = ^{display_control[31:8], display_control[3:1]};

    // Wrap detection, PWM lit decision and next anode/cathode pattern.
    always_comb begin
        prescale_wrap = (prescale == PRESCALE_LAST);
        sub_wrap      = prescale_wrap && (sub == 4'd15);
        frame_end     = sub_wrap && (digit == 3'd7);
        lit           = display_control[0] && (sub <= bright_snap);
        anode_next    = '1;
        cathode_next  = '1;
        if (lit) begin
            anode_next   = ~(8'h01 << digit);
            cathode_next = ~data_snap[{digit, 3'b000} +: 8];
        end
    end

    // Free-running prescale -> sub-slot -> digit counter chain.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prescale <= '0;
            sub      <= '0;
            digit    <= '0;
        end else begin
            prescale <= prescale_wrap ? '0 : prescale + 1'b1;
            if (prescale_wrap) begin
                sub <= sub + 4'd1;
                if (sub_wrap) begin
                    digit <= digit + 3'd1;
                end
            end
        end
    end

    // Capture segment data and brightness once per frame so no digit tears.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_snap   <= '0;
            bright_snap <= '0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end) begin
                data_snap   <= sevenseg_data;
                bright_snap <= display_control[7:4];
            end
        end
    end

    // Registered display drive; anode and cathode always move together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            anode_n   <= '1;
            cathode_n <= '1;
        end else begin
            anode_n   <= anode_next;
            cathode_n <= cathode_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// tb_sevenseg_scanner: self-checking bench for sevenseg_scanner with a
// cycle-count based reference model and directed scenario checks.
module tb_sevenseg_scanner;

    localparam int unsigned N     = 2;
    localparam int unsigned SLOT  = 16 * N;
    localparam int unsigned FRAME = 128 * N;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] sevenseg_data;
    logic [31:0] display_control;
    logic [7:0]  anode_n;
    logic [7:0]  cathode_n;
    logic        frame_tick;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    sevenseg_scanner #(.SUB_SLOT_CYCLES(N)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .sevenseg_data   (sevenseg_data),
        .display_control (display_control),
        .anode_n         (anode_n),
        .cathode_n       (cathode_n),
        .frame_tick      (frame_tick)
    );

    always #5 clock = ~clock;

    // Reference model: position in frame from a linear cycle count since reset.
    int unsigned m_cyc, m_pos, m_digit, m_sub;
    logic [63:0] m_data;
    logic [3:0]  m_bright;
    logic        m_lit;
    logic [7:0]  e_anode, e_cathode;
    logic        e_tick;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_cyc     = 0;
            m_data    = '0;
            m_bright  = '0;
            e_anode   = 8'hFF;
            e_cathode = 8'hFF;
            e_tick    = 1'b0;
        end else begin
            m_pos     = m_cyc % FRAME;
            m_digit   = m_pos / SLOT;
            m_sub     = (m_pos / N) % 16;
            m_lit     = display_control[0] && (m_sub <= m_bright);
            e_tick    = (m_pos == FRAME - 1);
            e_anode   = m_lit ? (8'hFF ^ (8'h01 << m_digit)) : 8'hFF;
            e_cathode = m_lit ? ~m_data[m_digit*8 +: 8] : 8'hFF;
            if (e_tick) begin
                m_data   = sevenseg_data;
                m_bright = display_control[7:4];
            end
            m_cyc++;
        end
    end

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clock);
            if (frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic exp_tick;
        reset_n = 1'b0;
        display_control = '0;
        sevenseg_data = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_hold i=%0d got %h %h %b want ff ff 0", i, anode_n, cathode_n, frame_tick);
            end
        end
        reset_n = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clock);
            exp_tick = (k == FRAME);
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {8'hFF, 8'hFF, exp_tick}) begin
                miscompares++;
                $display("FAIL reset_first_frame k=%0d got %h %h %b want ff ff %b", k, anode_n, cathode_n, frame_tick, exp_tick);
            end
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {e_anode, e_cathode, e_tick}) begin
                miscompares++;
                $display("FAIL reset_model k=%0d got %h %h %b want %h %h %b", k, anode_n, cathode_n, frame_tick, e_anode, e_cathode, e_tick);
            end
        end
    endtask

    task automatic test_scan();
        bit found;
        int unsigned d;
        logic [7:0] wa, wc;
        sevenseg_data = 64'h3F;
        display_control = 32'hF1;
        wait_tick(found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL scan_tick_timeout got none want frame_tick within %0d", FRAME + 4);
        end
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clock);
            d  = (j - 1) / SLOT;
            wa = 8'hFF ^ (8'h01 << d);
            wc = (d == 0) ? 8'hC0 : 8'hFF;
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {wa, wc, (j == FRAME)}) begin
                miscompares++;
                $display("FAIL scan j=%0d got %h %h %b want %h %h %b", j, anode_n, cathode_n, frame_tick, wa, wc, (j == FRAME));
            end
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {e_anode, e_cathode, e_tick}) begin
                miscompares++;
                $display("FAIL scan_model j=%0d got %h %h %b want %h %h %b", j, anode_n, cathode_n, frame_tick, e_anode, e_cathode, e_tick);
            end
        end
    endtask

    task automatic test_brightness();
        bit found;
        int unsigned d;
        logic lit;
        logic [63:0] dat;
        logic [7:0] wa, wc;
        dat = {$urandom, $urandom};
        sevenseg_data = dat;
        display_control = 32'h31;
        wait_tick(found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL bright_tick_timeout got none want frame_tick");
        end
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clock);
            d   = (j - 1) / SLOT;
            lit = ((j - 1) % SLOT) < 8;
            wa  = lit ? (8'hFF ^ (8'h01 << d)) : 8'hFF;
            wc  = lit ? ~dat[d*8 +: 8] : 8'hFF;
            vectors++;
            if ({anode_n, cathode_n} !== {wa, wc}) begin
                miscompares++;
                $display("FAIL brightness3 j=%0d got %h %h want %h %h", j, anode_n, cathode_n, wa, wc);
            end
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {e_anode, e_cathode, e_tick}) begin
                miscompares++;
                $display("FAIL bright_model j=%0d got %h %h %b want %h %h %b", j, anode_n, cathode_n, frame_tick, e_anode, e_cathode, e_tick);
            end
        end
    endtask

    task automatic test_midframe();
        bit found;
        sevenseg_data = 64'h3F;
        display_control = 32'hF1;
        wait_tick(found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_tick_timeout got none want frame_tick");
        end
        for (int j = 1; j <= FRAME + 1; j++) begin
            @(negedge clock);
            if (j == 1) begin
                vectors++;
                if ({anode_n, cathode_n} !== {8'hFE, 8'hC0}) begin
                    miscompares++;
                    $display("FAIL mid_old_data got %h %h want fe c0", anode_n, cathode_n);
                end
            end
            if (j == FRAME + 1) begin
                vectors++;
                if ({anode_n, cathode_n} !== {8'hFE, 8'hF9}) begin
                    miscompares++;
                    $display("FAIL mid_new_data got %h %h want fe f9", anode_n, cathode_n);
                end
            end
            vectors++;
            if (frame_tick !== (j == FRAME)) begin
                miscompares++;
                $display("FAIL mid_tick_spacing j=%0d got %b want %b", j, frame_tick, (j == FRAME));
            end
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {e_anode, e_cathode, e_tick}) begin
                miscompares++;
                $display("FAIL mid_model j=%0d got %h %h %b want %h %h %b", j, anode_n, cathode_n, frame_tick, e_anode, e_cathode, e_tick);
            end
            if (j == 10) sevenseg_data = 64'h06;
        end
    endtask

    task automatic test_enable();
        bit found;
        logic [63:0] dat;
        dat = {$urandom, $urandom};
        sevenseg_data = dat;
        display_control = 32'hF1;
        wait_tick(found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL en_tick_timeout got none want frame_tick");
        end
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clock);
            if (j >= 82 && j <= 91) begin
                vectors++;
                if ({anode_n, cathode_n} !== {8'hFF, 8'hFF}) begin
                    miscompares++;
                    $display("FAIL enable_off j=%0d got %h %h want ff ff", j, anode_n, cathode_n);
                end
            end
            if (j == 92) begin
                vectors++;
                if ({anode_n, cathode_n} !== {8'hFB, ~dat[23:16]}) begin
                    miscompares++;
                    $display("FAIL enable_resume got %h %h want fb %h", anode_n, cathode_n, ~dat[23:16]);
                end
            end
            vectors++;
            if (frame_tick !== (j == FRAME)) begin
                miscompares++;
                $display("FAIL enable_phase j=%0d got %b want %b", j, frame_tick, (j == FRAME));
            end
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {e_anode, e_cathode, e_tick}) begin
                miscompares++;
                $display("FAIL en_model j=%0d got %h %h %b want %h %h %b", j, anode_n, cathode_n, frame_tick, e_anode, e_cathode, e_tick);
            end
            if (j == 81) display_control = 32'hF0;
            if (j == 91) display_control = 32'hF1;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        sevenseg_data = '1;
        display_control = 32'hF1;
        wait_tick(found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rmid_tick_timeout got none want frame_tick");
        end
        for (int j = 1; j <= 50; j++) begin
            @(negedge clock);
            if (j == 1) begin
                vectors++;
                if ({anode_n, cathode_n} !== {8'hFE, 8'h00}) begin
                    miscompares++;
                    $display("FAIL rmid_lit got %h %h want fe 00", anode_n, cathode_n);
                end
            end
        end
        reset_n = 1'b0;
        @(negedge clock);
        vectors++;
        if ({anode_n, cathode_n, frame_tick} !== {8'hFF, 8'hFF, 1'b0}) begin
            miscompares++;
            $display("FAIL rmid_blank got %h %h %b want ff ff 0", anode_n, cathode_n, frame_tick);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clock);
            vectors++;
            if (cathode_n !== 8'hFF || frame_tick !== (k == FRAME)) begin
                miscompares++;
                $display("FAIL rmid_dark k=%0d got %h %b want ff %b", k, cathode_n, frame_tick, (k == FRAME));
            end
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {e_anode, e_cathode, e_tick}) begin
                miscompares++;
                $display("FAIL rmid_model k=%0d got %h %h %b want %h %h %b", k, anode_n, cathode_n, frame_tick, e_anode, e_cathode, e_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            vectors++;
            if ({anode_n, cathode_n, frame_tick} !== {e_anode, e_cathode, e_tick}) begin
                miscompares++;
                $display("FAIL random i=%0d got %h %h %b want %h %h %b", i, anode_n, cathode_n, frame_tick, e_anode, e_cathode, e_tick);
            end
            reset_n = 1'b1;
            if ($urandom_range(39, 0) == 0) sevenseg_data = {$urandom, $urandom};
            if ($urandom_range(49, 0) == 0) display_control = $urandom;
            if ($urandom_range(599, 0) == 0) reset_n = 1'b0;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        sevenseg_data = '0;
        display_control = '0;
        test_reset();
        test_scan();
        test_brightness();
        test_midframe();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
